// File: rtl/norm_lod_20_if.sv
// norm_lod_20_if: handshake bundle for the norm_lod_20 normalisation stage.
//   in_valid / in_ready / in_data      : upstream magnitude stream (20b unsigned)
//   out_valid / out_ready              : downstream result handshake
//   out_mant / out_exp / out_zero      : normalised mantissa, leading-one position, zero flag
// Modports: master = producer of inputs / consumer of results (bench, upstream+packer);
//           slave  = the normalisation stage itself.
interface norm_lod_20_if #(
  parameter int MANT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [19:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [4:0]        out_exp;
  logic              out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero
  );
endinterface

// File: rtl/norm_lod_20.sv
// norm_lod_20: two-stage normalisation pipeline for the uno PE accumulator.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : norm_lod_20_if.slave (in_valid/in_ready/in_data, out_valid/out_ready,
//          out_mant/out_exp/out_zero)
// S1 registers the magnitude with its 1-based leading-one position; S2 shifts the
// leading one to bit 19, strips it and registers mantissa/exponent/zero.
// Optional macro NORM_LOD_ROUND_EN: round-to-nearest-even in S2 (exp may reach 21).
// Without it the mantissa is truncated.
module norm_lod_20 #(
  parameter int MANT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  norm_lod_20_if.slave bus
);

  // 1-based index of the highest set bit, 0 for an all-zero word.
  function automatic logic [4:0] lod_pos(input logic [19:0] d);
    lod_pos = '0;
    for (int i = 0; i < 20; i++) begin
      if (d[i]) lod_pos = 5'(i + 1);
    end
  endfunction

  // Bits [18 : 19-MANT_W] of the normalised word; bit 19 is the hidden one.
  function automatic logic [MANT_W-1:0] mant_trunc(input logic [19:0] sh);
    mant_trunc = MANT_W'(sh >> (19 - MANT_W));
  endfunction

`ifdef NORM_LOD_ROUND_EN
  function automatic logic guard_bit(input logic [19:0] sh);
    guard_bit = sh[18 - MANT_W];
  endfunction

  // Range below the guard bit is empty when MANT_W = 18; the loop then runs zero times.
  function automatic logic sticky_bits(input logic [19:0] sh);
    sticky_bits = 1'b0;
    for (int i = 0; i < 18 - MANT_W; i++) begin
      sticky_bits = sticky_bits | sh[i];
    end
  endfunction

  // Returns {carry, rounded mantissa}; carry set when an all-ones mantissa wraps.
  function automatic logic [MANT_W:0] round_rne(input logic [MANT_W-1:0] m,
                                                input logic g, input logic s);
    logic inc;
    inc       = g && (s || m[0]);
    round_rne = {1'b0, m} + {{MANT_W{1'b0}}, inc};
  endfunction
`endif

  logic              s1_en, s2_en;
  logic              s1_vld_q, s1_vld_d;
  logic [19:0]       s1_data_q, s1_data_d;
  logic [4:0]        s1_pos_q, s1_pos_d;
  logic              s2_vld_q, s2_vld_d;
  logic [MANT_W-1:0] mant_q, mant_d, mant_n;
  logic [4:0]        exp_q, exp_d, exp_n;
  logic              zero_q, zero_d, zero_n;
  logic [19:0]       shifted;

  // No skid buffer: in_ready is combinational through both stages from out_ready.
  assign s2_en        = !s2_vld_q || bus.out_ready;
  assign s1_en        = !s1_vld_q || s2_en;
  assign bus.in_ready = s1_en;

  // ---- S1: capture input and leading-one position ----
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s1_pos_d  = s1_pos_q;
    if (s1_en) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_data_d = bus.in_data;
        s1_pos_d  = lod_pos(bus.in_data);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_vld_q <= 1'b0;
    else     s1_vld_q <= s1_vld_d;
  end

  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
    s1_pos_q  <= s1_pos_d;
  end

  // ---- S2: normalise, strip hidden bit, optional rounding ----
  always_comb begin
    shifted = s1_data_q << (5'd20 - s1_pos_q);
    mant_n  = mant_trunc(shifted);
    exp_n   = s1_pos_q;
    zero_n  = 1'b0;
`ifdef NORM_LOD_ROUND_EN
    begin
      logic [MANT_W:0] r;
      r      = round_rne(mant_n, guard_bit(shifted), sticky_bits(shifted));
      mant_n = r[MANT_W-1:0];
      exp_n  = s1_pos_q + {4'd0, r[MANT_W]};
    end
`endif
    if (s1_pos_q == 5'd0) begin
      mant_n = '0;
      exp_n  = '0;
      zero_n = 1'b1;
    end

    s2_vld_d = s2_vld_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    zero_d   = zero_q;
    if (s2_en) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        mant_d = mant_n;
        exp_d  = exp_n;
        zero_d = zero_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      mant_q   <= '0;
      exp_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      s2_vld_q <= s2_vld_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      zero_q   <= zero_d;
    end
  end

  // ---- Output: driven straight from S2 ----
  assign bus.out_valid = s2_vld_q;
  assign bus.out_mant  = mant_q;
  assign bus.out_exp   = exp_q;
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_norm_lod_20.sv
module tb_norm_lod_20;
  localparam int MANT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  norm_lod_20_if #(.MANT_W(MANT_W)) bus ();
  norm_lod_20 #(.MANT_W(MANT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [15:0] mant;
    logic [4:0]  exp;
    logic        zero;
  } res_t;

  // Arithmetic reference: scale the value so the leading one lands at bit MANT_W.
  function automatic res_t model(input logic [19:0] d);
    res_t r;
    longint unsigned v, m;
    int pos;
    logic g, s;
    pos = 0;
    for (int i = 19; i >= 0; i--) if (d[i] && pos == 0) pos = i + 1;
    r.mant = '0; r.exp = '0; r.zero = 1'b0;
    if (pos == 0) begin
      r.zero = 1'b1;
      return r;
    end
    v = longint'(d);
    m = ((v << (MANT_W + 1)) >> pos) & ((64'd1 << MANT_W) - 1);
    g = 1'(((v << (MANT_W + 2)) >> pos) & 64'd1);
    s = (pos - MANT_W - 2 > 0) ? ((v & ((64'd1 << (pos - MANT_W - 2)) - 1)) != 0) : 1'b0;
    r.exp = 5'(pos);
`ifdef NORM_LOD_ROUND_EN
    if (g && (s || m[0])) begin
      m = m + 1;
      if (m == (64'd1 << MANT_W)) begin
        m = 0;
        r.exp = 5'(pos + 1);
      end
    end
`else
    if (g && s) r.exp = 5'(pos);
`endif
    r.mant = 16'(m);
    return r;
  endfunction

  // Drives one vector into an empty pipeline; reports result and whether
  // out_valid rose exactly on the second edge.
  task automatic run_one(input logic [19:0] d, output res_t r, output logic lat_ok);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat_ok = !bus.out_valid;
    @(posedge clk); #1;
    lat_ok = lat_ok && bus.out_valid;
    r.mant = bus.out_mant;
    r.exp  = bus.out_exp;
    r.zero = bus.out_zero;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_mant !== 16'h0 || bus.out_exp !== 5'd0 || bus.out_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b mant=%h exp=%0d zero=%b, required 0/0000/0/0",
               bus.out_valid, bus.out_mant, bus.out_exp, bus.out_zero);
    end
    @(negedge clk) rst = 1'b0;
    // Fill the pipeline under backpressure, then reset mid-stream.
    bus.in_valid = 1'b1; bus.in_data = 20'h12345;
    @(negedge clk) bus.in_data = 20'h00F00;
    @(negedge clk) bus.in_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_fill: out_valid=%b, required 1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_mant !== 16'h0 || bus.out_exp !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_async: valid=%b mant=%h exp=%0d, required 0/0000/0",
               bus.out_valid, bus.out_mant, bus.out_exp);
    end
    @(negedge clk) rst = 1'b0;
    bus.out_ready = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
        if (bus.out_valid) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_flush: stale output after reset, got valid=1, required none");
      end
    end
  endtask

  task automatic test_zero;
    res_t r; logic lat;
    run_one(20'h00000, r, lat);
    tests_run++;
    if (r.zero !== 1'b1 || r.mant !== 16'h0 || r.exp !== 5'd0 || lat !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_input: zero=%b mant=%h exp=%0d lat_ok=%b, required 1/0000/0/1",
               r.zero, r.mant, r.exp, lat);
    end
  endtask

  task automatic test_single_bit;
    res_t r; logic lat;
    run_one(20'h00001, r, lat);
    tests_run++;
    if (r.exp !== 5'd1 || r.mant !== 16'h0000 || r.zero !== 1'b0 || lat !== 1'b1) begin
      tests_failed++;
      $display("FAIL bit0: exp=%0d mant=%h zero=%b lat_ok=%b, required 1/0000/0/1",
               r.exp, r.mant, r.zero, lat);
    end
    run_one(20'h00C00, r, lat);
    tests_run++;
    if (r.exp !== 5'd12 || r.mant !== 16'h8000 || r.zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL c00: exp=%0d mant=%h zero=%b, required 12/8000/0", r.exp, r.mant, r.zero);
    end
    run_one(20'h80000, r, lat);
    tests_run++;
    if (r.exp !== 5'd20 || r.mant !== 16'h0000) begin
      tests_failed++;
      $display("FAIL bit19: exp=%0d mant=%h, required 20/0000", r.exp, r.mant);
    end
  endtask

  task automatic test_full_scale;
    res_t r; logic lat;
    run_one(20'hFFFFF, r, lat);
    tests_run++;
`ifdef NORM_LOD_ROUND_EN
    if (r.mant !== 16'h0000 || r.exp !== 5'd21) begin
      tests_failed++;
      $display("FAIL full_scale: mant=%h exp=%0d, required 0000/21", r.mant, r.exp);
    end
`else
    if (r.mant !== 16'hFFFF || r.exp !== 5'd20) begin
      tests_failed++;
      $display("FAIL full_scale: mant=%h exp=%0d, required ffff/20", r.mant, r.exp);
    end
`endif
  endtask

  task automatic test_ties;
    res_t r; logic lat;
    run_one(20'hA0004, r, lat);
    tests_run++;
    if (r.mant !== 16'h4000 || r.exp !== 5'd20) begin
      tests_failed++;
      $display("FAIL tie_even: mant=%h exp=%0d, required 4000/20", r.mant, r.exp);
    end
    run_one(20'hA000C, r, lat);
    tests_run++;
`ifdef NORM_LOD_ROUND_EN
    if (r.mant !== 16'h4002 || r.exp !== 5'd20) begin
      tests_failed++;
      $display("FAIL tie_odd: mant=%h exp=%0d, required 4002/20", r.mant, r.exp);
    end
`else
    if (r.mant !== 16'h4001 || r.exp !== 5'd20) begin
      tests_failed++;
      $display("FAIL tie_odd: mant=%h exp=%0d, required 4001/20", r.mant, r.exp);
    end
`endif
  endtask

  task automatic test_backpressure;
    res_t q[$];
    res_t e, ra;
    logic c_acc;
    int got;
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 20'h00C00;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_accept_a: in_ready=%b, required 1", bus.in_ready);
    end
    q.push_back(model(20'h00C00));
    @(negedge clk);
    bus.in_data = 20'h12345;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_accept_b: in_ready=%b, required 1", bus.in_ready);
    end
    q.push_back(model(20'h12345));
    @(negedge clk);
    bus.in_data = 20'h00007;
    #1;
    ra = model(20'h00C00);
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_mant !== ra.mant || bus.out_exp !== ra.exp) begin
      tests_failed++;
      $display("FAIL bp_full: in_ready=%b valid=%b mant=%h exp=%0d, required 0/1/%h/%0d",
               bus.in_ready, bus.out_valid, bus.out_mant, bus.out_exp, ra.mant, ra.exp);
    end
    @(negedge clk); #1;
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_mant !== ra.mant || bus.out_exp !== ra.exp) begin
      tests_failed++;
      $display("FAIL bp_stable: in_ready=%b mant=%h exp=%0d, required 0/%h/%0d",
               bus.in_ready, bus.out_mant, bus.out_exp, ra.mant, ra.exp);
    end
    c_acc = 1'b0; got = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      if (c_acc) bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(20'h00007));
        c_acc = 1'b1;
      end
      if (bus.out_valid) begin
        got++;
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL bp_order: extra output mant=%h, required none", bus.out_mant);
        end else begin
          e = q.pop_front();
          if (bus.out_mant !== e.mant || bus.out_exp !== e.exp || bus.out_zero !== e.zero) begin
            tests_failed++;
            $display("FAIL bp_order: mant=%h exp=%0d, required %h/%0d",
                     bus.out_mant, bus.out_exp, e.mant, e.exp);
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (got !== 3 || c_acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_count: outputs=%0d c_accepted=%b, required 3/1", got, c_acc);
    end
  endtask

  task automatic test_streaming;
    res_t q[$];
    res_t e;
    int sent, recv, errs;
    logic acc;
    logic ok_rdy, ok_vld;
    sent = 0; recv = 0; errs = 0; acc = 1'b1;
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && recv < 100; cyc++) begin
      @(negedge clk);
      if (acc || !bus.in_valid) begin
        bus.in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
        bus.in_data  = 20'($urandom) >> $urandom_range(0, 20);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        q.push_back(model(bus.in_data));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        recv++;
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL stream_out: unexpected output mant=%h", bus.out_mant);
        end else begin
          e = q.pop_front();
          if (bus.out_mant !== e.mant || bus.out_exp !== e.exp || bus.out_zero !== e.zero) begin
            tests_failed++;
            errs++;
            if (errs < 5)
              $display("FAIL stream_out: mant=%h exp=%0d zero=%b, required %h/%0d/%b",
                       bus.out_mant, bus.out_exp, bus.out_zero, e.mant, e.exp, e.zero);
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (recv !== 100 || q.size() !== 0) begin
      tests_failed++;
      $display("FAIL stream_count: received=%0d pending=%0d, required 100/0", recv, q.size());
    end
    // Full-rate phase: 10 inputs on consecutive edges, outputs 2 edges later each.
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    ok_rdy = 1'b1; ok_vld = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.in_valid = (k < 10);
      bus.in_data  = 20'h01000 + 20'(k * 37);
      #1;
      if (k < 10) begin
        if (!bus.in_ready) ok_rdy = 1'b0;
        else q.push_back(model(bus.in_data));
      end
      if ((k >= 2) !== bus.out_valid) ok_vld = 1'b0;
      if (bus.out_valid && q.size() != 0) begin
        e = q.pop_front();
        tests_run++;
        if (bus.out_mant !== e.mant || bus.out_exp !== e.exp) begin
          tests_failed++;
          $display("FAIL rate_out: mant=%h exp=%0d, required %h/%0d",
                   bus.out_mant, bus.out_exp, e.mant, e.exp);
        end
      end
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (ok_rdy !== 1'b1 || ok_vld !== 1'b1 || q.size() !== 0) begin
      tests_failed++;
      $display("FAIL rate_timing: in_ready_ok=%b valid_timing_ok=%b pending=%0d, required 1/1/0",
               ok_rdy, ok_vld, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single_bit();
    test_full_scale();
    test_ties();
    @(negedge clk);
    @(negedge clk);
    test_backpressure();
    test_streaming();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/norm_lod_20.md
Name: norm_lod_20

Overview:
- Normalisation stage of the 16b-fraction uno PE, sitting directly downstream of the accumulator's leading-one position logic.
- Takes a 20-bit unsigned accumulated magnitude and finds its leading-one position, 1-based (0 when the input is zero).
- Left-shifts the value so the leading one is at bit 19, then emits a hidden-bit-stripped mantissa plus an exponent.
- Two-stage pipeline with valid/ready handshake on both sides, so it can be stalled by the downstream packer.

Parameters:
- MANT_W, 16, output mantissa width in bits; legal range 1..18.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  stage can accept in_data this cycle
- in_data  input  20  unsigned magnitude
- out_valid  output  1  out_* fields are valid
- out_ready  input  1  downstream accepts this cycle
- out_mant  output  MANT_W  normalised mantissa, hidden bit removed
- out_exp  output  5  leading-one position, 0..20 (21 allowed with rounding)
- out_zero  output  1  input was all zeros

Behaviour:
- Reset: s1_valid, s2_valid and out_valid are 0; out_mant, out_exp and out_zero are 0. Reset is asynchronous and active-high, and applies mid-transfer too: in-flight data is dropped with no partial output.
- Transfer rule: a transfer occurs on a port when valid && ready at a rising clk edge.
- Stage 1 (S1), on accept:
  - register in_data into s1_data.
  - register pos = index of highest set bit + 1 (bit19 gives 20, bit0 gives 1, none gives 0) into s1_pos.
- Stage 2 (S2), on advance from S1:
  - shifted[19:0] = s1_data << (20 - s1_pos), truncated to 20 bits; valid for s1_pos >= 1.
  - mant = shifted[18 : 19-MANT_W].
  - guard = shifted[18-MANT_W].
  - sticky = OR of shifted[17-MANT_W : 0], or 0 if that range is empty.
  - exp = s1_pos.
  - zero: when s1_pos == 0, mant = 0, exp = 0 and zero = 1, regardless of rounding.
- Output fields are driven directly from S2 registers; out_valid = s2_valid.
- Flow control:
  - s2 advance enable = !s2_valid || out_ready.
  - s1 advance enable = !s1_valid || s2 advance enable.
  - in_ready = s1 advance enable (combinational from out_ready, no skid buffer).
- Latency and throughput: 2 cycles from input transfer to out_valid when there is no stall; 1 result per cycle sustained with out_ready held high.
- Stall behaviour:
  - out_valid && !out_ready holds all out_* stable.
  - With both stages full, in_ready = 0 and no data is lost or duplicated.
- Simultaneous events: an output transfer and an input transfer in the same cycle are legal; the pipeline shifts and keeps full occupancy.
- Bubbles: when in_valid = 0 on an accept-capable edge, s1_valid goes to 0. Payload registers may hold stale data while their valid bit is 0.

Optional Feature:
- Macro: NORM_LOD_ROUND_EN.
- Defined: S2 applies round-to-nearest-even.
  - Increment mant when guard && (sticky || mant[0]).
  - If mant was all ones, mant wraps to 0 and exp = s1_pos + 1; this only reaches 21 when s1_pos = 20.
  - Zero input is unaffected.
  - Latency is unchanged.
- Undefined: truncation only. Guard and sticky are not computed, and out_exp never exceeds 20.

Test Plan (MANT_W = 16):
- Reset and zero input: assert rst mid-stream -> out_valid = 0 immediately. Then in_data = 20'h00000 -> 2 cycles later out_zero = 1, out_mant = 0, out_exp = 0.
- Single bit: in_data = 20'h00001 -> out_exp = 1, out_mant = 16'h0000. in_data = 20'h00C00 -> out_exp = 12, out_mant = 16'h8000.
- Full scale: in_data = 20'hFFFFF.
  - Without the macro -> out_mant = 16'hFFFF, out_exp = 20.
  - With NORM_LOD_ROUND_EN -> out_mant = 16'h0000, out_exp = 21.
- Ties, with NORM_LOD_ROUND_EN:
  - in_data = 20'hA0004 -> out_mant = 16'h4000 (tie, stays even).
  - in_data = 20'hA000C -> out_mant = 16'h4002.
  - Both give out_exp = 20.
- Backpressure: out_ready = 0 and present 3 back-to-back inputs -> first 2 accepted, in_ready = 0 on the 3rd, out_* stable. Release out_ready -> all 3 outputs emerge in order, none dropped or duplicated.
- Streaming: 100 random inputs with random out_ready -> every output matches a reference model and ordering is preserved. At out_ready = 1 the throughput is 1 per cycle and latency is 2.
